// File: rtl/mock_cpu_pkg.sv
// Shared helpers for the streaming mock CPU load generator: the per-stage
// mock-compute function and the round-robin pointer width.
package mock_cpu_pkg;

  function automatic int rr_ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Arithmetic is done at 64 bits and masked once at the end; the low bits of
  // xor, left-shift and add depend only on the low bits of their operands.
  function automatic logic [63:0] mock_stage(input logic [63:0] x, input int s,
                                             input int width, input int work);
    logic [63:0] acc;
    acc = x;
    for (int w = 0; w < work; w++) begin
      acc = (acc ^ (acc << 1)) + 64'(w) * 64'(s);
    end
    return (width >= 64) ? acc : (acc & ((64'd1 << width) - 64'd1));
  endfunction

endpackage

// File: rtl/mock_cpu_core.sv
// One elastic mock-compute pipeline: per-stage valid bits, bubbles collapse,
// backpressure ripples combinationally from out_ready_i to in_ready_o.
module mock_cpu_core
  import mock_cpu_pkg::*;
#(
  parameter int PIPELINE_DEPTH = 4,
  parameter int WORK_PER_STAGE = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int CORE_W         = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CORE_W-1:0]     core_idx_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  busy_o
);

  logic [PIPELINE_DEPTH-1:0] vld_q, vld_d;
  logic [PIPELINE_DEPTH-1:0] stg_ready;
  logic [DATA_WIDTH-1:0]     data_q   [PIPELINE_DEPTH];
  logic                      stg_in_vld [PIPELINE_DEPTH];
  logic [DATA_WIDTH-1:0]     stg_in_dat [PIPELINE_DEPTH];

  // A stage can take new data if it, or any stage downstream of it, is empty,
  // or if the consumer is taking the last stage.
  always_comb begin : p_ready
    logic r;
    for (int k = 0; k < PIPELINE_DEPTH; k++) begin
      r = out_ready_i;
      for (int j = k; j < PIPELINE_DEPTH; j++) begin
        r = r | ~vld_q[j];
      end
      stg_ready[k] = r;
    end
  end

  for (genvar k = 0; k < PIPELINE_DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign stg_in_vld[k] = in_valid_i;
      assign stg_in_dat[k] = DATA_WIDTH'(mock_stage(
          64'(in_data_i + DATA_WIDTH'(core_idx_i)), 0, DATA_WIDTH, WORK_PER_STAGE));
    end else begin : g_next
      assign stg_in_vld[k] = vld_q[k-1];
      assign stg_in_dat[k] = DATA_WIDTH'(mock_stage(
          64'(data_q[k-1]), k, DATA_WIDTH, WORK_PER_STAGE));
    end
  end

  always_comb begin
    vld_d = vld_q;
    for (int k = 0; k < PIPELINE_DEPTH; k++) begin
      if (stg_ready[k]) vld_d[k] = stg_in_vld[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_q <= '0;
    else        vld_q <= vld_d;
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < PIPELINE_DEPTH; k++) begin
      if (stg_ready[k] && stg_in_vld[k]) data_q[k] <= stg_in_dat[k];
    end
  end

  assign in_ready_o  = stg_ready[0];
  assign out_valid_o = vld_q[PIPELINE_DEPTH-1];
  assign out_data_o  = data_q[PIPELINE_DEPTH-1];
  assign busy_o      = |vld_q;

endmodule

// File: rtl/mock_cpu_stream.sv
// Streaming mock CPU: round-robin dispatch to NUM_CORES elastic pipelines and
// in-order round-robin collection into a single output register.
module mock_cpu_stream
  import mock_cpu_pkg::*;
#(
  parameter int NUM_CORES      = 2,
  parameter int PIPELINE_DEPTH = 4,
  parameter int WORK_PER_STAGE = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] out_count
);

  localparam int            RW   = rr_ptr_w(NUM_CORES);
  localparam logic [RW-1:0] LAST = RW'(NUM_CORES - 1);

  logic [RW-1:0]          rr_in_q, rr_in_d, rr_out_q, rr_out_d;
  logic                   out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
  logic [COUNT_WIDTH-1:0] out_count_q, out_count_d;

  logic [NUM_CORES-1:0]   c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_busy;
  logic [DATA_WIDTH-1:0]  c_out_data [NUM_CORES];
  logic                   out_free, accept, load_out, deliver;

  assign out_free = !out_valid_q || out_ready;

  for (genvar c = 0; c < NUM_CORES; c++) begin : g_core
    assign c_in_valid[c]  = in_valid && (rr_in_q == RW'(c));
    // Only the core at rr_out may drain, which keeps results in input order.
    assign c_out_ready[c] = out_free && (rr_out_q == RW'(c));

    mock_cpu_core #(
      .PIPELINE_DEPTH(PIPELINE_DEPTH),
      .WORK_PER_STAGE(WORK_PER_STAGE),
      .DATA_WIDTH    (DATA_WIDTH),
      .CORE_W        (RW)
    ) u_core (
      .clk        (clk),
      .rst_n      (rst_n),
      .core_idx_i (RW'(c)),
      .in_valid_i (c_in_valid[c]),
      .in_ready_o (c_in_ready[c]),
      .in_data_i  (in_data),
      .out_valid_o(c_out_valid[c]),
      .out_ready_i(c_out_ready[c]),
      .out_data_o (c_out_data[c]),
      .busy_o     (c_busy[c])
    );
  end

  assign in_ready = c_in_ready[rr_in_q];
  assign accept   = in_valid && in_ready;
  assign load_out = c_out_valid[rr_out_q] && out_free;
  assign deliver  = out_valid_q && out_ready;

  always_comb begin
    rr_in_d     = rr_in_q;
    rr_out_d    = rr_out_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q + COUNT_WIDTH'(deliver);
    if (accept) rr_in_d = (rr_in_q == LAST) ? '0 : rr_in_q + RW'(1);
    if (load_out) begin
      rr_out_d    = (rr_out_q == LAST) ? '0 : rr_out_q + RW'(1);
      out_valid_d = 1'b1;
      out_data_d  = c_out_data[rr_out_q];
    end else if (deliver) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_in_q     <= '0;
      rr_out_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
    end else begin
      rr_in_q     <= rr_in_d;
      rr_out_q    <= rr_out_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;
  assign busy      = (|c_busy) || out_valid_q;

endmodule

// File: tb/tb_mock_cpu_stream.sv
// Bench for mock_cpu_stream: a small directed instance (2 cores, depth 1,
// 8-bit, 2-bit counter) and a default-parameter instance for a random soak.
module tb_mock_cpu_stream;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Directed instance
  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
  logic [7:0] a_in_data, a_out_data;
  logic [1:0] a_out_count;

  // Soak instance
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic [31:0] b_in_data, b_out_data;
  logic [15:0] b_out_count;

  mock_cpu_stream #(.NUM_CORES(2), .PIPELINE_DEPTH(1), .WORK_PER_STAGE(1),
                    .DATA_WIDTH(8), .COUNT_WIDTH(2)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .busy(a_busy), .out_count(a_out_count));

  mock_cpu_stream #(.NUM_CORES(2), .PIPELINE_DEPTH(4), .WORK_PER_STAGE(8),
                    .DATA_WIDTH(32), .COUNT_WIDTH(16)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .busy(b_busy), .out_count(b_out_count));

  int n_run  = 0;
  int n_fail = 0;

  logic [63:0] qa[$];
  logic [63:0] qb[$];
  int rra, rrb, cnta, cntb;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Independent reference: token + core index, then each stage's mock loop.
  function automatic logic [63:0] ref_model(input logic [63:0] din, input int idx,
                                            input int depth, input int work, input int dw);
    logic [63:0] m, x;
    m = (dw >= 64) ? '1 : ((64'd1 << dw) - 64'd1);
    x = (din + 64'(idx)) & m;
    for (int s = 0; s < depth; s++)
      for (int w = 0; w < work; w++)
        x = ((x ^ (x << 1)) + 64'(w * s)) & m;
    return x;
  endfunction

  task automatic mon_a();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        qa.delete(); rra = 0; cnta = 0;
      end else begin
        check("a_count", 64'(a_out_count), 64'(cnta));
        if (a_out_valid) begin
          if (qa.size() == 0) check("a_spurious_valid", 64'(a_out_valid), 64'd0);
          else begin
            check("a_data", 64'(a_out_data), qa[0]);
            if (a_out_ready) begin
              void'(qa.pop_front());
              cnta = (cnta + 1) % 4;
            end
          end
        end
        if (a_in_valid && a_in_ready) begin
          qa.push_back(ref_model(64'(a_in_data), rra, 1, 1, 8));
          rra = (rra + 1) % 2;
        end
      end
    end
  endtask

  task automatic mon_b();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        qb.delete(); rrb = 0; cntb = 0;
      end else begin
        check("b_count", 64'(b_out_count), 64'(cntb));
        if (b_out_valid) begin
          if (qb.size() == 0) check("b_spurious_valid", 64'(b_out_valid), 64'd0);
          else begin
            check("b_data", 64'(b_out_data), qb[0]);
            if (b_out_ready) begin
              void'(qb.pop_front());
              cntb = (cntb + 1) % 65536;
            end
          end
        end
        if (b_in_valid && b_in_ready) begin
          qb.push_back(ref_model(64'(b_in_data), rrb, 4, 8, 32));
          rrb = (rrb + 1) % 2;
        end
      end
    end
  endtask

  // Called just after a rising edge; returns just after the edge that took the token.
  task automatic send_a(input logic [7:0] d);
    int t;
    a_in_data  = d;
    a_in_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!a_in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!a_in_ready) check("a_accept_timeout", 64'(a_in_ready), 64'd1);
    @(posedge clk); #1;
    a_in_valid = 1'b0;
  endtask

  task automatic send_chk_a(input logic [7:0] d, input logic [7:0] exp);
    send_a(d);
    @(negedge clk);
    check("a_lat_early", 64'(a_out_valid), 64'd0);
    @(negedge clk);
    check("a_lat_valid", 64'(a_out_valid), 64'd1);
    check("a_lat_data", 64'(a_out_data), 64'(exp));
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] toks [5];
    logic [1:0] cexp [5];
    int k, acc, t;
    toks = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    cexp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    rst_n = 1'b0;
    a_in_valid = 0; a_in_data = '0; a_out_ready = 0;
    b_in_valid = 0; b_in_data = '0; b_out_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_a_out_valid", 64'(a_out_valid), 64'd0);
    check("rst_a_out_data",  64'(a_out_data),  64'd0);
    check("rst_a_busy",      64'(a_busy),      64'd0);
    check("rst_a_count",     64'(a_out_count), 64'd0);
    check("rst_b_busy",      64'(b_busy),      64'd0);
    check("rst_b_out_valid", 64'(b_out_valid), 64'd0);
    rst_n = 1'b1;
    fork
      mon_a();
      mon_b();
    join_none
    @(negedge clk);
    check("a_in_ready_after_rst", 64'(a_in_ready), 64'd1);
    check("b_in_ready_after_rst", 64'(b_in_ready), 64'd1);

    // Basic and wrap arithmetic
    @(posedge clk); #1;
    a_out_ready = 1'b1;
    send_chk_a(8'h01, 8'h03);
    send_chk_a(8'h01, 8'h06);
    check("a_basic_count", 64'(a_out_count), 64'd2);
    send_chk_a(8'h80, 8'h80);
    send_chk_a(8'hFF, 8'h00);

    // Backpressure: only 2*1+1 tokens fit
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    k = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      a_in_data = toks[k];
      @(negedge clk);
      if (a_in_ready) k++;
      @(posedge clk); #1;
    end
    a_in_valid = 1'b0;
    check("a_bp_accepted", 64'(k), 64'd3);
    @(negedge clk);
    check("a_bp_in_ready", 64'(a_in_ready), 64'd0);
    check("a_bp_head", 64'(a_out_data), 64'h33);
    repeat (3) @(negedge clk);
    check("a_bp_held", 64'(a_out_data), 64'h33);
    @(posedge clk); #1;
    a_out_ready = 1'b1;
    t = 0;
    while (a_busy && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    check("a_bp_drained", 64'(a_busy), 64'd0);
    check("a_bp_sb_empty", 64'(qa.size()), 64'd0);

    // Reset with tokens in flight
    a_out_ready = 1'b0;
    send_a(8'h5A);
    send_a(8'hA5);
    send_a(8'h3C);
    check("a_pre_rst_busy", 64'(a_busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("a_mid_rst_out_valid", 64'(a_out_valid), 64'd0);
    check("a_mid_rst_busy",      64'(a_busy),      64'd0);
    check("a_mid_rst_count",     64'(a_out_count), 64'd0);
    check("a_mid_rst_rr_in",     64'(dut_a.rr_in_q),  64'd0);
    check("a_mid_rst_rr_out",    64'(dut_a.rr_out_q), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Counter wrap; first token must land in core 0
    a_out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send_chk_a(8'h01, (i % 2 == 0) ? 8'h03 : 8'h06);
      check("a_cnt_wrap", 64'(a_out_count), 64'(cexp[i]));
    end

    // Full-rate throughput on the default instance
    b_out_ready = 1'b1;
    b_in_valid  = 1'b1;
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      b_in_data = $urandom;
      @(negedge clk);
      if (b_in_ready) acc++;
      @(posedge clk); #1;
    end
    check("b_throughput", 64'(acc), 64'd20);

    // Random-stall soak
    for (int i = 0; i < 3000; i++) begin
      b_in_valid  = 1'($urandom_range(0, 1));
      b_out_ready = ($urandom_range(0, 3) != 0);
      b_in_data   = $urandom;
      @(posedge clk); #1;
    end
    b_in_valid  = 1'b0;
    b_out_ready = 1'b1;
    t = 0;
    while (b_busy && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    check("b_soak_busy", 64'(b_busy), 64'd0);
    check("b_soak_sb_empty", 64'(qb.size()), 64'd0);
    check("b_soak_out_valid", 64'(b_out_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
